// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mdu_pkg
// Brief   : Shared encodings for the multiply/divide unit (operation codes,
//           controller states, down-counter width).
// Revision: 1.0 - initial release
// ============================================================================
package mdu_pkg;

  localparam int MDU_CNT_W = 4;

  typedef enum logic [2:0] {
    MDU_MULT  = 3'b000,
    MDU_MULTU = 3'b001,
    MDU_DIV   = 3'b010,
    MDU_DIVU  = 3'b011,
    MDU_MTHI  = 3'b100,
    MDU_MTLO  = 3'b101,
    MDU_MADD  = 3'b110,
    MDU_MADDU = 3'b111
  } mdu_op_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mdu_state_t;

endpackage
`default_nettype wire

// File: rtl/mdu_if.sv
`default_nettype none
// ============================================================================
// Module  : mdu_if
// Brief   : EX-stage to MDU bus: operands, opcode, start/busy handshake and
//           the architectural HI/LO read-back.
// Revision: 1.0 - initial release
// ============================================================================
interface mdu_if;
  logic [31:0] A;
  logic [31:0] B;
  logic [2:0]  MDUOp;
  logic        start;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (output A, B, MDUOp, start, input busy, HI, LO);
  modport slave  (input A, B, MDUOp, start, output busy, HI, LO);
endinterface
`default_nettype wire

// File: rtl/mdu_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : mdu_ctrl
// Brief   : IDLE/BUSY sequencer with a 4-bit down-counter. Holds busy for
//           exactly N cycles and pulses commit in the last busy cycle.
// Revision: 1.0 - initial release
// ============================================================================
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic i_launch,
  input  logic i_is_div,
  output logic o_busy,
  output logic o_commit
);

  // Counter is loaded with N-1 so that counts N-1..0 give N busy cycles.
  localparam logic [MDU_CNT_W-1:0] c_mult_load = MDU_CNT_W'(MULT_CYCLES - 1);
  localparam logic [MDU_CNT_W-1:0] c_div_load  = MDU_CNT_W'(DIV_CYCLES - 1);

  mdu_state_t             r_state, w_state_nxt;
  logic [MDU_CNT_W-1:0]   r_cnt, w_cnt_nxt;

  // State and counter registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state: launch loads the cycle budget, BUSY counts down to zero.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (i_launch) begin
          w_state_nxt = BUSY;
          w_cnt_nxt   = i_is_div ? c_div_load : c_mult_load;
        end
      end
      BUSY: begin
        if (r_cnt == '0) begin
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt - MDU_CNT_W'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign o_busy   = (r_state == BUSY);
  assign o_commit = (r_state == BUSY) && (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/mdu.sv
`default_nettype none
// ============================================================================
// Module  : mdu
// Brief   : Multi-cycle multiply/divide unit with architectural HI/LO.
//           The result is computed at launch, parked in a 64-bit temp and
//           written to HI/LO when the controller's busy window closes.
//           Optional macro MDU_MADD_EN enables madd/maddu accumulation;
//           without it opcodes 110/111 are ignored.
// Revision: 1.0 - initial release
// ============================================================================
module mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic  clk,
  input  logic  reset,
  mdu_if.slave  bus
);

  logic        w_busy;
  logic        w_commit;
  logic        w_long;
  logic        w_is_div;
  logic        w_launch;
  logic        w_idle_start;
  logic [63:0] w_result;

  logic [63:0] w_a_sx, w_b_sx, w_prod_s, w_prod_u;
  logic        w_sdiv_ovf;
  logic [31:0] w_bdiv_s, w_bdiv_u;
  logic signed [31:0] w_squot, w_srem;
  logic [31:0] w_uquot, w_urem;

  logic [31:0] r_hi, r_lo;
  logic [63:0] r_temp;
  logic        r_dz;
`ifdef MDU_MADD_EN
  logic        r_acc;
`endif

  // Decode which opcodes occupy the unit for a multi-cycle window.
  always_comb begin
    w_long = 1'b0;
    case (bus.MDUOp)
      MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: w_long = 1'b1;
`ifdef MDU_MADD_EN
      MDU_MADD, MDU_MADDU:                    w_long = 1'b1;
`endif
      default:                                w_long = 1'b0;
    endcase
  end

  assign w_is_div     = (bus.MDUOp == MDU_DIV) || (bus.MDUOp == MDU_DIVU);
  assign w_idle_start = bus.start && !w_busy;
  assign w_launch     = w_idle_start && w_long;

  // Sign-/zero-extended operands keep the low 64 product bits exact.
  assign w_a_sx   = {{32{bus.A[31]}}, bus.A};
  assign w_b_sx   = {{32{bus.B[31]}}, bus.B};
  assign w_prod_s = w_a_sx * w_b_sx;
  assign w_prod_u = {32'd0, bus.A} * {32'd0, bus.B};

  // Divisor forced to 1 for B==0 (result discarded anyway) and for the
  // signed overflow case, where A/1 gives the wanted 0x80000000 rem 0.
  assign w_sdiv_ovf = (bus.A == 32'h8000_0000) && (bus.B == 32'hFFFF_FFFF);
  assign w_bdiv_s   = ((bus.B == '0) || w_sdiv_ovf) ? 32'd1 : bus.B;
  assign w_bdiv_u   = (bus.B == '0) ? 32'd1 : bus.B;
  assign w_squot    = $signed(bus.A) / $signed(w_bdiv_s);
  assign w_srem     = $signed(bus.A) % $signed(w_bdiv_s);
  assign w_uquot    = bus.A / w_bdiv_u;
  assign w_urem     = bus.A % w_bdiv_u;

  // Result selection; divides pack {remainder, quotient} as {HI, LO}.
  always_comb begin
    w_result = '0;
    case (bus.MDUOp)
      MDU_MULT:  w_result = w_prod_s;
      MDU_MULTU: w_result = w_prod_u;
      MDU_DIV:   w_result = {w_srem, w_squot};
      MDU_DIVU:  w_result = {w_urem, w_uquot};
      MDU_MADD:  w_result = w_prod_s;
      MDU_MADDU: w_result = w_prod_u;
      default:   w_result = '0;
    endcase
  end

  mdu_ctrl #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_ctrl (
    .clk      (clk),
    .reset    (reset),
    .i_launch (w_launch),
    .i_is_div (w_is_div),
    .o_busy   (w_busy),
    .o_commit (w_commit)
  );

  // Operand/result latch at launch, HI/LO commit at window end, and
  // direct mthi/mtlo writes while idle (launch and commit never coincide).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hi   <= '0;
      r_lo   <= '0;
      r_temp <= '0;
      r_dz   <= 1'b0;
`ifdef MDU_MADD_EN
      r_acc  <= 1'b0;
`endif
    end else if (w_launch) begin
      r_temp <= w_result;
      r_dz   <= w_is_div && (bus.B == '0);
`ifdef MDU_MADD_EN
      r_acc  <= (bus.MDUOp == MDU_MADD) || (bus.MDUOp == MDU_MADDU);
`endif
    end else if (w_commit) begin
      if (!r_dz) begin
`ifdef MDU_MADD_EN
        if (r_acc) {r_hi, r_lo} <= {r_hi, r_lo} + r_temp;
        else       {r_hi, r_lo} <= r_temp;
`else
        {r_hi, r_lo} <= r_temp;
`endif
      end
    end else if (w_idle_start && (bus.MDUOp == MDU_MTHI)) begin
      r_hi <= bus.A;
    end else if (w_idle_start && (bus.MDUOp == MDU_MTLO)) begin
      r_lo <= bus.A;
    end
  end

  assign bus.busy = w_busy;
  assign bus.HI   = r_hi;
  assign bus.LO   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mdu.sv
`default_nettype none
// ============================================================================
// Module  : tb_mdu
// Brief   : Scoreboard bench for mdu: expected HI/LO and busy length are
//           queued at issue and compared when busy drops.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mdu;
  import mdu_pkg::*;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
    string       name;
  } exp_t;

  logic clk;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];

  mdu_if bus ();

  mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one op at the current negedge for one cycle and queue its result.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ehi, input logic [31:0] elo, input int ecyc,
                       input string nm);
    exp_t e;
    e.hi = ehi; e.lo = elo; e.cyc = ecyc; e.name = nm;
    sb.push_back(e);
    bus.MDUOp = op; bus.A = a; bus.B = b; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Count busy negedges until idle, bounded.
  task automatic wait_idle(output int c);
    c = 0;
    while (bus.busy === 1'b1 && c < 40) begin
      c++;
      @(negedge clk);
    end
    n_checks++;
    if (c >= 40) begin n_fail++; $display("FAIL busy_timeout: busy still %b after %0d cycles", bus.busy, c); end
  endtask

  task automatic write_hilo(input logic [31:0] hi, input logic [31:0] lo);
    bus.start = 1'b1; bus.MDUOp = MDU_MTHI; bus.A = hi;
    @(negedge clk);
    bus.MDUOp = MDU_MTLO; bus.A = lo;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    reset = 1'b1; bus.start = 1'b0; bus.A = '0; bus.B = '0; bus.MDUOp = MDU_MULT;
    repeat (2) @(negedge clk);
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    n_checks++; if ({bus.HI, bus.LO} !== 64'd0) begin n_fail++; $display("FAIL reset_hilo: got %h expected 0", {bus.HI, bus.LO}); end
    reset = 1'b0;
    @(negedge clk);
    write_hilo(32'hAA, 32'hBB);
    issue(MDU_DIV, 32'd100, 32'd7, 32'd2, 32'd14, 10, "div_reset");
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL async_reset_busy: got %b expected 0", bus.busy); end
    n_checks++; if ({bus.HI, bus.LO} !== 64'd0) begin n_fail++; $display("FAIL async_reset_hilo: got %h expected 0", {bus.HI, bus.LO}); end
    e = sb.pop_front();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if ({bus.busy, bus.HI, bus.LO} !== 65'd0) begin n_fail++; $display("FAIL post_reset_idle: got %h expected 0", {bus.busy, bus.HI, bus.LO}); end
  endtask

  // Table of long operations, each checked for busy length and HI/LO.
  task automatic test_arith();
    logic [2:0]  ops [7] = '{MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIV, MDU_DIVU, MDU_DIV, MDU_MULT};
    logic [31:0] as  [7] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'd7, 32'd100, 32'h8000_0000, 32'h0001_0000};
    logic [31:0] bs  [7] = '{32'd3, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 32'd7, 32'hFFFF_FFFF, 32'h0001_0000};
    logic [31:0] eh  [7] = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd1, 32'd2, 32'd0, 32'd1};
    logic [31:0] el  [7] = '{32'hFFFF_FFFA, 32'h0000_0001, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'd14, 32'h8000_0000, 32'd0};
    int          ec  [7] = '{5, 5, 10, 10, 10, 10, 5};
    exp_t e;
    int   c;
    for (int i = 0; i < 7; i++) begin
      issue(ops[i], as[i], bs[i], eh[i], el[i], ec[i], $sformatf("arith%0d", i));
      wait_idle(c);
      e = sb.pop_front();
      n_checks++; if (c !== e.cyc) begin n_fail++; $display("FAIL %s_busy: got %0d cycles expected %0d", e.name, c, e.cyc); end
      n_checks++; if (bus.HI !== e.hi) begin n_fail++; $display("FAIL %s_hi: got %h expected %h", e.name, bus.HI, e.hi); end
      n_checks++; if (bus.LO !== e.lo) begin n_fail++; $display("FAIL %s_lo: got %h expected %h", e.name, bus.LO, e.lo); end
    end
  endtask

  task automatic test_div_by_zero();
    exp_t e;
    int   c;
    write_hilo(32'h11, 32'h22);
    issue(MDU_DIVU, 32'd7, 32'd0, 32'h11, 32'h22, 10, "divzero");
    bus.start = 1'b1; bus.MDUOp = MDU_MTHI; bus.A = 32'd5;
    @(negedge clk);
    bus.start = 1'b0;
    n_checks++; if (bus.HI !== 32'h11) begin n_fail++; $display("FAIL mthi_while_busy: got %h expected 11", bus.HI); end
    wait_idle(c);
    c = c + 1;
    e = sb.pop_front();
    n_checks++; if (c !== e.cyc) begin n_fail++; $display("FAIL %s_busy: got %0d cycles expected %0d", e.name, c, e.cyc); end
    n_checks++; if ({bus.HI, bus.LO} !== {e.hi, e.lo}) begin n_fail++; $display("FAIL %s_hilo: got %h expected %h", e.name, {bus.HI, bus.LO}, {e.hi, e.lo}); end
  endtask

  task automatic test_mtlo();
    logic saw_busy;
    saw_busy = 1'b0;
    bus.start = 1'b1; bus.MDUOp = MDU_MTLO; bus.A = 32'h1234;
    @(negedge clk);
    bus.start = 1'b0;
    n_checks++; if (bus.LO !== 32'h1234) begin n_fail++; $display("FAIL mtlo_lo: got %h expected 1234", bus.LO); end
    for (int i = 0; i < 4; i++) begin
      if (bus.busy !== 1'b0) saw_busy = 1'b1;
      @(negedge clk);
    end
    n_checks++; if (saw_busy !== 1'b0) begin n_fail++; $display("FAIL mtlo_busy: got %b expected 0", saw_busy); end
  endtask

  // Second op issued in the first idle cycle after the first commit.
  task automatic test_back_to_back();
    logic [31:0] a, b;
    logic [63:0] p;
    exp_t e;
    int   c;
    a = 32'h1234_5678; b = 32'h9ABC_DEF0;
    p = 64'(a) * 64'(b);
    issue(MDU_MULTU, a, b, p[63:32], p[31:0], 5, "b2b_multu");
    wait_idle(c);
    e = sb.pop_front();
    n_checks++; if ({c, bus.HI, bus.LO} !== {e.cyc, e.hi, e.lo}) begin n_fail++; $display("FAIL %s: got %0d %h %h expected %0d %h %h", e.name, c, bus.HI, bus.LO, e.cyc, e.hi, e.lo); end
    issue(MDU_DIVU, 32'd1000, 32'd33, 32'd10, 32'd30, 10, "b2b_divu");
    wait_idle(c);
    e = sb.pop_front();
    n_checks++; if ({c, bus.HI, bus.LO} !== {e.cyc, e.hi, e.lo}) begin n_fail++; $display("FAIL %s: got %0d %h %h expected %0d %h %h", e.name, c, bus.HI, bus.LO, e.cyc, e.hi, e.lo); end
  endtask

`ifdef MDU_MADD_EN
  task automatic test_madd();
    exp_t e;
    int   c;
    write_hilo(32'd0, 32'hFFFF_FFFF);
    issue(MDU_MADDU, 32'd1, 32'd1, 32'd1, 32'd0, 5, "maddu");
    wait_idle(c);
    e = sb.pop_front();
    n_checks++; if ({c, bus.HI, bus.LO} !== {e.cyc, e.hi, e.lo}) begin n_fail++; $display("FAIL %s: got %0d %h %h expected %0d %h %h", e.name, c, bus.HI, bus.LO, e.cyc, e.hi, e.lo); end
    issue(MDU_MADD, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'hFFFF_FFFF, 5, "madd");
    wait_idle(c);
    e = sb.pop_front();
    n_checks++; if ({c, bus.HI, bus.LO} !== {e.cyc, e.hi, e.lo}) begin n_fail++; $display("FAIL %s: got %0d %h %h expected %0d %h %h", e.name, c, bus.HI, bus.LO, e.cyc, e.hi, e.lo); end
  endtask
`else
  task automatic test_madd_noop();
    logic saw_busy;
    saw_busy = 1'b0;
    write_hilo(32'h33, 32'h44);
    bus.start = 1'b1; bus.MDUOp = MDU_MADD; bus.A = 32'd3; bus.B = 32'd4;
    @(negedge clk);
    if (bus.busy !== 1'b0) saw_busy = 1'b1;
    bus.MDUOp = MDU_MADDU;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (bus.busy !== 1'b0) saw_busy = 1'b1;
      @(negedge clk);
    end
    n_checks++; if (saw_busy !== 1'b0) begin n_fail++; $display("FAIL madd_noop_busy: got %b expected 0", saw_busy); end
    n_checks++; if ({bus.HI, bus.LO} !== {32'h33, 32'h44}) begin n_fail++; $display("FAIL madd_noop_hilo: got %h expected 0000003300000044", {bus.HI, bus.LO}); end
  endtask
`endif

  initial begin
    @(negedge clk);
    test_reset();
    test_arith();
    test_div_by_zero();
    test_mtlo();
    test_back_to_back();
`ifdef MDU_MADD_EN
    test_madd();
`else
    test_madd_noop();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mdu.md
Name: mdu

Overview:
- Multi-cycle multiply/divide unit beside the single-cycle ALU in the EX stage.
- Accepts an operation under a start/busy handshake and computes multiply or divide over a fixed number of cycles.
- Commits results to the architectural HI/LO registers.
- The pipeline stalls on busy; mfhi/mflo read HI/LO directly.

Parameters:
- MULT_CYCLES, 5, cycles busy is held for mult/multu (and madd/maddu when enabled); legal range 1..15.
- DIV_CYCLES, 10, cycles busy is held for div/divu; legal range 1..15.

Ports:
- clk    input   1   rising-edge clock
- reset  input   1   asynchronous, active-high; clears all state
- A      input   32  operand A (rs)
- B      input   32  operand B (rt)
- MDUOp  input   3   000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo, 110 madd, 111 maddu
- start  input   1   MDUOp/A/B valid this cycle
- busy   output  1   operation in flight; start is ignored while high
- HI     output  32  HI register
- LO     output  32  LO register

Behaviour:
- Reset (async, any state, including mid-operation):
  - HI=0, LO=0, busy=0, state IDLE, counter 0.
  - In-flight result discarded.
- Two states, IDLE and BUSY; 4-bit down-counter.
- IDLE with start=1 at edge k:
  - mult/multu/madd/maddu/div/divu: A and B latched (computed result latched into internal 64-bit temp); counter := N-1 (N = MULT_CYCLES or DIV_CYCLES); go BUSY; busy=1 from after edge k.
  - mthi/mtlo: HI := A (or LO := A) at edge k; stay IDLE; busy stays 0.
- BUSY:
  - Counter decrements each edge.
  - At the edge where counter==0: commit temp to HI/LO, go IDLE, busy falls.
  - busy is high for exactly N cycles; new HI/LO visible in the first cycle busy=0.
- start while busy=1 (any op, including mthi/mtlo): ignored; no state change.
- start with busy=0 in the cycle after commit: accepted normally, giving back-to-back operation.
- Arithmetic:
  - mult: signed 32x32 -> 64; HI = [63:32], LO = [31:0].
  - multu: unsigned 32x32 -> 64; HI = [63:32], LO = [31:0].
  - div: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - divu: unsigned quotient/remainder.
  - div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0x00000000.
- Divide by zero (B=0, div or divu): busy still held DIV_CYCLES; HI/LO unchanged at commit.
- MDUOp 110/111 with the feature compiled out: treated as no-op; stay IDLE; busy=0; HI/LO unchanged.
- Outputs HI, LO, busy are registered (state-derived only); no combinational path from inputs.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined:
  - 110 madd: {HI,LO} := {HI,LO} + signed(A)*signed(B), mod 2^64.
  - 111 maddu: {HI,LO} := {HI,LO} + unsigned(A)*unsigned(B), mod 2^64.
  - Both take MULT_CYCLES.
  - Accumulation uses the HI/LO value at the commit edge; HI/LO cannot change while busy.
- Undefined: 110/111 are no-ops as above; no accumulate adder is synthesized.

Decomposition:
- Shared package mdu_pkg holds:
  - MDUOp encodings (MDU_MULT..MDU_MADDU).
  - State encodings IDLE/BUSY.
  - Counter width constant (4).
- One natural sub-module: mdu_ctrl, the IDLE/BUSY FSM plus down-counter, producing busy and a one-cycle commit strobe.
- Datapath (operand latch, temp, HI/LO) stays in mdu.

Test Plan:
- reset pulse mid-div (3 cycles into BUSY) -> busy=0, HI=0, LO=0 immediately, without waiting for a clock edge.
- mult A=0xFFFFFFFE (-2), B=3 -> busy high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- multu A=0xFFFFFFFF, B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001 after 5 cycles.
- div A=-7 (0xFFFFFFF9), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF after 10 cycles.
- divu A=7, B=0 with prior HI=0x11, LO=0x22:
  - busy held 10 cycles; HI/LO stay 0x11/0x22.
  - mthi A=5 issued during busy -> ignored.
- mtlo A=0x1234 in IDLE -> LO=0x1234 next cycle, busy never rises.
- With MDU_MADD_EN: HI=0, LO=0xFFFFFFFF, then maddu A=1, B=1 -> HI=1, LO=0.
